// File: rtl/cpu_instr_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module : cpu_instr_sequencer_pkg
//  Brief  : Opcode class constants, field positions and sequencer state codes
//  Rev    : 1.0  initial release
// ============================================================================
package cpu_instr_sequencer_pkg;

    localparam int OPC_MSB = 19;
    localparam int OPC_LSB = 18;

    typedef enum logic [1:0] {
        OPC_HALT  = 2'b00,
        OPC_ARITH = 2'b01,
        OPC_LOAD  = 2'b10,
        OPC_STORE = 2'b11
    } opc_class_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

    function automatic logic is_busy_state(input seq_state_e st);
        return (st == ST_FETCH) || (st == ST_ISSUE) || (st == ST_HOLD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_instr_sequencer_seq_prog_mem.sv
`default_nettype none
// ============================================================================
//  Module : seq_prog_mem
//  Brief  : Program store, one write port and one registered read port
//  Rev    : 1.0  initial release
// ============================================================================
module seq_prog_mem #(
    parameter int WIDTH     = 20,
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] waddr_i,
    input  logic [WIDTH-1:0]     wdata_i,
    input  logic [ADDR_BITS-1:0] raddr_i,
    output logic [WIDTH-1:0]     rdata_o
);

    // No reset on the array: the program survives a sequencer reset.
    logic [WIDTH-1:0] mem_q [2**ADDR_BITS];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/cpu_instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module : cpu_instr_sequencer
//  Brief  : Steps a loadable program store and holds each word for the CPU.
//           Define SEQ_LOOP_EN to restart at pc=0 on HALT/end of store.
//  Rev    : 1.0  initial release
// ============================================================================
module cpu_instr_sequencer
    import cpu_instr_sequencer_pkg::*;
#(
    parameter int INSTR_WIDTH    = 20,
    parameter int PROG_ADDR_BITS = 4,
    parameter int HOLD_CYCLES    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      prog_we,
    input  logic [PROG_ADDR_BITS-1:0] prog_addr,
    input  logic [INSTR_WIDTH-1:0]    prog_data,
    input  logic                      start,
    input  logic                      abort,
    output logic [INSTR_WIDTH-1:0]    instruction,
    output logic                      instr_strobe,
    output logic [PROG_ADDR_BITS-1:0] pc,
    output logic                      busy,
    output logic                      done
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]          C_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [PROG_ADDR_BITS-1:0] C_PC_MAX    = '1;

    seq_state_e                state_q, state_d;
    logic [PROG_ADDR_BITS-1:0] pc_q, pc_d;
    logic [INSTR_WIDTH-1:0]    instr_q, instr_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      strobe_q, strobe_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      mem_we;
    logic                      halt_word;
    logic [INSTR_WIDTH-1:0]    rd_data;
`ifdef SEQ_LOOP_EN
    logic                      wrap;
`endif

    assign mem_we    = prog_we && !is_busy_state(state_q);
    assign halt_word = (rd_data[OPC_MSB:OPC_LSB] == OPC_HALT);

    seq_prog_mem #(
        .WIDTH     (INSTR_WIDTH),
        .ADDR_BITS (PROG_ADDR_BITS)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .raddr_i (pc_q),
        .rdata_o (rd_data)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        cnt_d    = cnt_q;
        strobe_d = 1'b0;
`ifdef SEQ_LOOP_EN
        wrap     = 1'b0;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                end
            end
            ST_FETCH: state_d = ST_ISSUE;
            ST_ISSUE: begin
                if (halt_word) begin
`ifdef SEQ_LOOP_EN
                    pc_d    = '0;
                    state_d = ST_FETCH;
                    wrap    = 1'b1;
`else
                    state_d = ST_DONE;
                    instr_d = '0;
`endif
                end else begin
                    instr_d  = rd_data;
                    cnt_d    = C_HOLD_LAST;
                    strobe_d = 1'b1;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (pc_q == C_PC_MAX) begin
                    // Running off the end of the store behaves like a HALT.
`ifdef SEQ_LOOP_EN
                    pc_d    = '0;
                    state_d = ST_FETCH;
                    wrap    = 1'b1;
`else
                    state_d = ST_DONE;
                    instr_d = '0;
`endif
                end else begin
                    pc_d    = pc_q + 1'b1;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // abort overrides everything, including a simultaneous start.
        if (abort) begin
            state_d  = ST_IDLE;
            pc_d     = '0;
            instr_d  = '0;
            cnt_d    = '0;
            strobe_d = 1'b0;
`ifdef SEQ_LOOP_EN
            wrap     = 1'b0;
`endif
        end

        busy_d = is_busy_state(state_d);
`ifdef SEQ_LOOP_EN
        done_d = wrap;
`else
        done_d = (state_d == ST_DONE);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            instr_q  <= '0;
            cnt_q    <= '0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign instruction  = instr_q;
    assign instr_strobe = strobe_q;
    assign pc           = pc_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module : tb_cpu_instr_sequencer
//  Brief  : Vector table, corner sequences and random run vs. schedule model
//  Rev    : 1.0  initial release
// ============================================================================
module tb_cpu_instr_sequencer;

    localparam int IW = 20;
    localparam int AB = 4;
    localparam int H  = 4;
    localparam int P  = H + 2;
    localparam int L  = 16;
`ifdef SEQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, prog_we, start, abort;
    logic [AB-1:0] prog_addr;
    logic [IW-1:0] prog_data;
    logic [IW-1:0] instruction;
    logic          instr_strobe, busy, done;
    logic [AB-1:0] pc;

    always #5 clk = ~clk;

    cpu_instr_sequencer #(
        .INSTR_WIDTH    (IW),
        .PROG_ADDR_BITS (AB),
        .HOLD_CYCLES    (H)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .start        (start),
        .abort        (abort),
        .instruction  (instruction),
        .instr_strobe (instr_strobe),
        .pc           (pc),
        .busy         (busy),
        .done         (done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: the store, a snapshot taken when a run starts, and edges since start.
    logic [IW-1:0] mem_m [L];
    logic [IW-1:0] snap  [L];
    bit            running = 1'b0;
    int            n = 0;

    function automatic int halt_idx();
        for (int i = 0; i < L; i++) if (snap[i][19:18] == 2'b00) return i;
        return -1;
    endfunction

    // Edges from the start edge until DONE (or until the loop wraps).
    function automatic int run_len();
        int h;
        h = halt_idx();
        return (h >= 0) ? h * P + 2 : L * P;
    endfunction

    function automatic logic [26:0] expected();
        logic b, d, s;
        logic [AB-1:0] p;
        logic [IW-1:0] ins, prev0;
        int m, i, st, h, c;
        b = 0; d = 0; s = 0; p = '0; ins = '0;
        if (running) begin
            h = halt_idx();
            c = run_len();
            if (!LOOP && n >= c) begin
                d = 1'b1;
                p = (h >= 0) ? AB'(h) : AB'(L - 1);
            end else begin
                m = n;
                prev0 = '0;
                if (n >= c) begin
                    m = n % c;
                    d = (m == 0);
                    prev0 = (h == 0) ? '0 : ((h > 0) ? snap[h-1] : snap[L-1]);
                end
                b   = 1'b1;
                i   = m / P;
                st  = m % P;
                p   = AB'(i);
                s   = (st == 2);
                ins = (st >= 2) ? snap[i] : ((i == 0) ? prev0 : snap[i-1]);
            end
        end
        return {b, d, s, p, ins};
    endfunction

    task automatic model_update();
        bit bsy;
        bsy = running && (LOOP || n < run_len());
        if (prog_we && !bsy) mem_m[prog_addr] = prog_data;
        if (!rst || abort) begin
            running = 1'b0;
        end else if (start && !bsy) begin
            snap    = mem_m;
            running = 1'b1;
            n       = 0;
        end else if (running) begin
            n++;
        end
    endtask

    task automatic check(input string name, input logic [26:0] act, input logic [26:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got busy=%0b done=%0b strobe=%0b pc=%0d instr=%05h, want busy=%0b done=%0b strobe=%0b pc=%0d instr=%05h",
                     name, act[26], act[25], act[24], act[23:20], act[19:0],
                     exp[26], exp[25], exp[24], exp[23:20], exp[19:0]);
        end
    endtask

    function automatic logic [26:0] outs();
        return {busy, done, instr_strobe, pc, instruction};
    endfunction

    task automatic tick(input bit r, input bit we, input logic [AB-1:0] a,
                        input logic [IW-1:0] d, input bit st, input bit ab);
        rst = r; prog_we = we; prog_addr = a; prog_data = d; start = st; abort = ab;
        @(posedge clk);
        model_update();
        @(negedge clk);
        check("model", outs(), expected());
    endtask

    task automatic idle(input int k);
        repeat (k) tick(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    typedef struct {
        bit            r, we, st, ab;
        logic [AB-1:0] a;
        logic [IW-1:0] d;
        int            gap;
        logic [26:0]   exp;
    } vec_t;

    function automatic vec_t v(input bit r, input bit we, input int a, input int d,
                               input bit st, input bit ab, input int gap,
                               input bit b, input bit dn, input bit s, input int p, input int ins);
        vec_t x;
        x.r = r; x.we = we; x.a = AB'(a); x.d = IW'(d); x.st = st; x.ab = ab; x.gap = gap;
        x.exp = {b, dn, s, AB'(p), IW'(ins)};
        return x;
    endfunction

    vec_t          tbl[$];
    int            strobes;
    bit            r_r, r_we, r_st, r_ab;
    logic [AB-1:0] r_a;
    logic [IW-1:0] r_d;

    initial begin
`ifndef SEQ_LOOP_EN
        //            r we a  data     st ab gap  busy done stb pc instr
        tbl.push_back(v(0, 0, 0, 'h00000, 0, 0, 1,  0, 0, 0, 0, 'h00000));
        tbl.push_back(v(1, 1, 0, 'h47000, 0, 0, 0,  0, 0, 0, 0, 'h00000));
        tbl.push_back(v(1, 1, 1, 'h53000, 0, 0, 0,  0, 0, 0, 0, 'h00000));
        tbl.push_back(v(1, 1, 2, 'h72001, 0, 0, 0,  0, 0, 0, 0, 'h00000));
        tbl.push_back(v(1, 1, 3, 'h00000, 0, 0, 0,  0, 0, 0, 0, 'h00000));
        tbl.push_back(v(1, 0, 0, 0,       1, 0, 0,  1, 0, 0, 0, 'h00000));
        tbl.push_back(v(1, 0, 0, 0,       0, 0, 0,  1, 0, 0, 0, 'h00000));
        tbl.push_back(v(1, 0, 0, 0,       0, 0, 0,  1, 0, 1, 0, 'h47000));
        tbl.push_back(v(1, 0, 0, 0,       0, 0, 0,  1, 0, 0, 0, 'h47000));
        tbl.push_back(v(1, 0, 0, 0,       0, 0, 4,  1, 0, 1, 1, 'h53000));
        tbl.push_back(v(1, 0, 0, 0,       0, 0, 5,  1, 0, 1, 2, 'h72001));
        tbl.push_back(v(1, 0, 0, 0,       0, 0, 5,  0, 1, 0, 3, 'h00000));
        tbl.push_back(v(1, 0, 0, 0,       0, 0, 3,  0, 1, 0, 3, 'h00000));
        // reset in the middle of word 1, then replay from the intact store
        tbl.push_back(v(1, 0, 0, 0,       1, 0, 3,  1, 0, 0, 0, 'h47000));
        tbl.push_back(v(1, 0, 0, 0,       0, 0, 5,  1, 0, 0, 1, 'h53000));
        tbl.push_back(v(0, 0, 0, 0,       0, 0, 0,  0, 0, 0, 0, 'h00000));
        tbl.push_back(v(1, 0, 0, 0,       1, 0, 2,  1, 0, 1, 0, 'h47000));
        // abort beats start, then a fresh start runs
        tbl.push_back(v(1, 0, 0, 0,       0, 0, 1,  1, 0, 0, 0, 'h47000));
        tbl.push_back(v(1, 0, 0, 0,       1, 1, 0,  0, 0, 0, 0, 'h00000));
        tbl.push_back(v(1, 0, 0, 0,       1, 0, 2,  1, 0, 1, 0, 'h47000));
        // write while busy is dropped; the same write in DONE takes effect
        tbl.push_back(v(1, 1, 1, 'h00000, 0, 0, 0,  1, 0, 0, 0, 'h47000));
        tbl.push_back(v(1, 0, 0, 0,       0, 0, 4,  1, 0, 1, 1, 'h53000));
        tbl.push_back(v(1, 0, 0, 0,       0, 0, 11, 0, 1, 0, 3, 'h00000));
        tbl.push_back(v(1, 1, 1, 'h00000, 0, 0, 0,  0, 1, 0, 3, 'h00000));
        tbl.push_back(v(1, 0, 0, 0,       1, 0, 2,  1, 0, 1, 0, 'h47000));
        tbl.push_back(v(1, 0, 0, 0,       0, 0, 5,  0, 1, 0, 1, 'h00000));

        for (int k = 0; k < tbl.size(); k++) begin
            tick(tbl[k].r, tbl[k].we, tbl[k].a, tbl[k].d, tbl[k].st, tbl[k].ab);
            idle(tbl[k].gap);
            check($sformatf("vec%0d", k), outs(), tbl[k].exp);
        end

        // Full store of non-HALT words: 16 issues, stop at pc=15 without wrapping.
        for (int i = 0; i < L; i++)
            tick(1'b1, 1'b1, AB'(i), {2'($urandom_range(1, 3)), 18'($urandom)}, 1'b0, 1'b0);
        tick(1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
        strobes = 0;
        for (int i = 0; i < L * P - 1; i++) begin
            idle(1);
            if (instr_strobe) strobes++;
        end
        check("full_last_hold", {busy, done, pc}, {1'b1, 1'b0, 4'd15});
        idle(1);
        check("full_done", {done, busy, instr_strobe, pc, instruction}, {3'b100, 4'd15, 20'h0});
        n_cmp++;
        if (strobes != L) begin
            n_bad++;
            $display("FAIL full_strobes: got %0d, want %0d", strobes, L);
        end
`else
        tick(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        check("loop_reset", outs(), 27'h0);
        tick(1'b1, 1'b1, 4'd0, 20'hD80F0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 4'd1, 20'h00000, 1'b0, 1'b0);
        tick(1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
        idle(2);
        check("loop_issue0", outs(), {3'b101, 4'd0, 20'hD80F0});
        idle(6);
        check("loop_wrap1", outs(), {3'b110, 4'd0, 20'hD80F0});
        idle(1);
        check("loop_pulse_end", outs(), {3'b100, 4'd0, 20'hD80F0});
        idle(1);
        check("loop_issue1", outs(), {3'b101, 4'd0, 20'hD80F0});
        idle(8);
        check("loop_issue2", outs(), {3'b101, 4'd0, 20'hD80F0});
        tick(1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
        check("loop_abort", outs(), 27'h0);
`endif

        // Seed every word so random runs never read an unwritten location.
        for (int i = 0; i < L; i++)
            tick(1'b1, 1'b1, AB'(i), {2'($urandom_range(0, 3)), 18'($urandom)}, 1'b0, 1'b0);

        for (int c = 0; c < 3000; c++) begin
            r_r  = ($urandom_range(0, 199) != 0);
            r_we = ($urandom_range(0, 3) == 0);
            r_a  = AB'($urandom);
            r_d  = {(($urandom_range(0, 5) == 0) ? 2'b00 : 2'($urandom_range(1, 3))), 18'($urandom)};
            r_st = ($urandom_range(0, 9) == 0);
            r_ab = ($urandom_range(0, 99) == 0);
            tick(r_r, r_we, r_a, r_d, r_st, r_ab);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
